// File: rtl/rggen_register_access_sequencer.sv
// Single-outstanding command sequencer: range-checks a bus command, broadcasts it to a register block
// and returns the selected register's response. Optional macro RGGEN_ACCESS_TIMEOUT_EN adds an access timeout.
module rggen_register_access_sequencer #(
    parameter int                         ADDRESS_WIDTH  = 8,
    parameter int                         BUS_WIDTH      = 32,
    parameter int                         REGISTERS      = 1,
    parameter logic [ADDRESS_WIDTH-1:0]   BASE_ADDRESS   = '0,
    parameter int                         BYTE_SIZE      = 256,
    parameter int                         TIMEOUT_CYCLES = 64
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           i_req_valid,
    output logic                           o_req_ready,
    input  logic [ADDRESS_WIDTH-1:0]       i_req_address,
    input  logic                           i_req_write,
    input  logic [BUS_WIDTH-1:0]           i_req_wdata,
    input  logic [BUS_WIDTH/8-1:0]         i_req_strobe,
    output logic                           o_rsp_valid,
    input  logic                           i_rsp_ready,
    output logic [1:0]                     o_rsp_status,
    output logic [BUS_WIDTH-1:0]           o_rsp_rdata,
    output logic                           o_access_valid,
    output logic [ADDRESS_WIDTH-1:0]       o_access_address,
    output logic                           o_access_write,
    output logic [BUS_WIDTH-1:0]           o_access_data,
    output logic [BUS_WIDTH/8-1:0]         o_access_strobe,
    input  logic [REGISTERS-1:0]           i_reg_active,
    input  logic [REGISTERS-1:0]           i_reg_ready,
    input  logic [2*REGISTERS-1:0]         i_reg_status,
    input  logic [BUS_WIDTH*REGISTERS-1:0] i_reg_value
);
    localparam int AW1 = ADDRESS_WIDTH + 1;

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] ACCESS   = 2'd1;
    localparam logic [1:0] RESPONSE = 2'd2;

    localparam logic [1:0] SLAVE_ERROR  = 2'd2;
    localparam logic [1:0] DECODE_ERROR = 2'd3;

    localparam logic [ADDRESS_WIDTH:0] BASE_EXT = {1'b0, BASE_ADDRESS};
    localparam logic [ADDRESS_WIDTH:0] SIZE_EXT = AW1'(BYTE_SIZE);

    logic [1:0]             state;
    logic [ADDRESS_WIDTH:0] addr_ext;
    logic [ADDRESS_WIDTH:0] offset;
    logic                   in_range;
    logic [REGISTERS-1:0]   sel;
    logic                   hit;
    logic                   none_active;
    logic [1:0]             sel_status;
    logic [BUS_WIDTH-1:0]   sel_value;
    logic                   timeout_hit;

    // One extra bit so an address below the base borrows out instead of wrapping into range.
    assign addr_ext = {1'b0, i_req_address};
    assign offset   = addr_ext - BASE_EXT;
    assign in_range = (addr_ext >= BASE_EXT) && (offset < SIZE_EXT);

    always_comb begin
        sel        = i_reg_active & i_reg_ready;
        sel_status = '0;
        sel_value  = '0;
        for (int k = 0; k < REGISTERS; k++) begin
            if (sel[k]) begin
                sel_status = sel_status | i_reg_status[2*k+:2];
                sel_value  = sel_value | i_reg_value[BUS_WIDTH*k+:BUS_WIDTH];
            end
        end
    end

    assign hit         = |sel;
    assign none_active = ~|i_reg_active;

`ifdef RGGEN_ACCESS_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] wait_count;

    always_ff @(posedge i_clk) begin
        if (i_rst || (state != ACCESS)) begin
            wait_count <= '0;
        end else if (!hit) begin
            wait_count <= wait_count + 1'b1;
        end
    end

    // The current cycle is the TIMEOUT_CYCLES-th access cycle without a selected ready.
    assign timeout_hit = (state == ACCESS) && !hit && (wait_count == CW'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state            <= IDLE;
            o_access_address <= '0;
            o_access_write   <= 1'b0;
            o_access_data    <= '0;
            o_access_strobe  <= '0;
            o_rsp_status     <= '0;
            o_rsp_rdata      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_req_valid) begin
                        if (in_range) begin
                            state            <= ACCESS;
                            o_access_address <= offset[ADDRESS_WIDTH-1:0];
                            o_access_write   <= i_req_write;
                            o_access_data    <= i_req_wdata;
                            o_access_strobe  <= i_req_write ? i_req_strobe : '1;
                        end else begin
                            state        <= RESPONSE;
                            o_rsp_status <= DECODE_ERROR;
                            o_rsp_rdata  <= '0;
                        end
                    end
                end
                ACCESS: begin
                    if (none_active) begin
                        state        <= RESPONSE;
                        o_rsp_status <= DECODE_ERROR;
                        o_rsp_rdata  <= '0;
                    end else if (hit) begin
                        state        <= RESPONSE;
                        o_rsp_status <= sel_status;
                        o_rsp_rdata  <= o_access_write ? '0 : sel_value;
                    end else if (timeout_hit) begin
                        state        <= RESPONSE;
                        o_rsp_status <= SLAVE_ERROR;
                        o_rsp_rdata  <= '0;
                    end
                end
                RESPONSE: begin
                    if (i_rsp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign o_req_ready    = (state == IDLE);
    assign o_access_valid = (state == ACCESS);
    assign o_rsp_valid    = (state == RESPONSE);

endmodule

// File: tb/tb_rggen_register_access_sequencer.sv
// Scoreboard bench: block at base 0x40, 32 bytes, two register slots, timeout of 4 cycles when enabled.
module tb_rggen_register_access_sequencer;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [7:0]  req_address = '0;
    logic        req_write = 1'b0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_strobe = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [1:0]  rsp_status;
    logic [31:0] rsp_rdata;
    logic        access_valid;
    logic [7:0]  access_address;
    logic        access_write;
    logic [31:0] access_data;
    logic [3:0]  access_strobe;
    logic [1:0]  reg_active = '0;
    logic [1:0]  reg_ready = '0;
    logic [3:0]  reg_status = '0;
    logic [63:0] reg_value = '0;

    int errors = 0;
    int checks = 0;
    int access_total = 0;
    logic [33:0] sb_q[$];

    always #5 clk = ~clk;

    always @(posedge clk) if (access_valid) access_total <= access_total + 1;

    rggen_register_access_sequencer #(
        .ADDRESS_WIDTH(8), .BUS_WIDTH(32), .REGISTERS(2),
        .BASE_ADDRESS(8'h40), .BYTE_SIZE(32), .TIMEOUT_CYCLES(TO)
    ) dut (
        .i_clk(clk), .i_rst(rst),
        .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_address(req_address),
        .i_req_write(req_write), .i_req_wdata(req_wdata), .i_req_strobe(req_strobe),
        .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_status(rsp_status),
        .o_rsp_rdata(rsp_rdata),
        .o_access_valid(access_valid), .o_access_address(access_address),
        .o_access_write(access_write), .o_access_data(access_data), .o_access_strobe(access_strobe),
        .i_reg_active(reg_active), .i_reg_ready(reg_ready), .i_reg_status(reg_status),
        .i_reg_value(reg_value)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [7:0] a, input logic w, input logic [31:0] d,
                         input logic [3:0] s, output logic accepted);
        req_valid   = 1'b1;
        req_address = a;
        req_write   = w;
        req_wdata   = d;
        req_strobe  = s;
        accepted    = req_ready;
        step();
        req_valid   = 1'b0;
    endtask

    task automatic collect(input int max, output logic ok, output logic [1:0] st,
                           output logic [31:0] rd);
        ok = 1'b0;
        st = '0;
        rd = '0;
        for (int i = 0; i < max && !ok; i++) begin
            if (rsp_valid) begin
                st        = rsp_status;
                rd        = rsp_rdata;
                rsp_ready = 1'b1;
                step();
                rsp_ready = 1'b0;
                ok        = 1'b1;
            end else begin
                step();
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++;
        if ({req_ready, rsp_valid, access_valid, access_write} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_ctrl got=%b exp=1000", {req_ready, rsp_valid, access_valid, access_write});
        end
        checks++;
        if ({rsp_status, rsp_rdata, access_address, access_data, access_strobe} !== 78'd0) begin
            errors++;
            $display("FAIL reset_data got=%h exp=0",
                     {rsp_status, rsp_rdata, access_address, access_data, access_strobe});
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_read();
        logic acc, ok;
        logic [1:0] st;
        logic [31:0] rd;
        logic [33:0] e;
        reg_active = 2'b10; reg_ready = 2'b10; reg_status = 4'b0001;
        reg_value  = {32'hDEADBEEF, 32'h11111111};
        sb_q.push_back({2'd0, 32'hDEADBEEF});
        issue(8'h44, 1'b0, 32'hFFFFFFFF, 4'h0, acc);
        checks++;
        if (acc !== 1'b1) begin errors++; $display("FAIL read_accept got=%b exp=1", acc); end
        checks++;
        if ({access_valid, rsp_valid, req_ready} !== 3'b100) begin
            errors++; $display("FAIL read_access_phase got=%b exp=100", {access_valid, rsp_valid, req_ready});
        end
        checks++;
        if ({access_address, access_write, access_strobe} !== {8'h04, 1'b0, 4'hF}) begin
            errors++;
            $display("FAIL read_access_fields got=%h/%b/%h exp=04/0/f", access_address, access_write, access_strobe);
        end
        step();
        checks++;
        if (rsp_valid !== 1'b1) begin errors++; $display("FAIL read_latency got=%b exp=1", rsp_valid); end
        collect(10, ok, st, rd);
        e = sb_q.pop_front();
        checks++;
        if (!ok) begin errors++; $display("FAIL read_rsp got=timeout exp=response"); end
        else if ({st, rd} !== e) begin errors++; $display("FAIL read_rsp got=%h exp=%h", {st, rd}, e); end
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL read_idle got=%b exp=1", req_ready); end
    endtask

    task automatic test_write();
        logic acc, ok;
        logic [1:0] st;
        logic [31:0] rd;
        logic [33:0] e;
        reg_active = 2'b01; reg_ready = 2'b01; reg_status = 4'b0000;
        reg_value  = {32'h0, 32'hCAFEF00D};
        sb_q.push_back({2'd0, 32'h0});
        issue(8'h48, 1'b1, 32'h12345678, 4'h3, acc);
        checks++;
        if ({access_valid, access_write, access_address, access_data, access_strobe} !==
            {1'b1, 1'b1, 8'h08, 32'h12345678, 4'h3}) begin
            errors++;
            $display("FAIL write_access got=%b/%b/%h/%h/%h exp=1/1/08/12345678/3",
                     access_valid, access_write, access_address, access_data, access_strobe);
        end
        collect(10, ok, st, rd);
        e = sb_q.pop_front();
        checks++;
        if (!ok) begin errors++; $display("FAIL write_rsp got=timeout exp=response"); end
        else if ({st, rd} !== e) begin errors++; $display("FAIL write_rsp got=%h exp=%h", {st, rd}, e); end
    endtask

    task automatic test_decode_error();
        logic acc, ok;
        logic [1:0] st;
        logic [31:0] rd;
        logic [33:0] e;
        logic [7:0] bad[2];
        int start;
        bad[0] = 8'h60;
        bad[1] = 8'h3F;
        reg_active = 2'b01; reg_ready = 2'b01; reg_value = {32'h0, 32'hA5A5A5A5}; reg_status = '0;
        for (int i = 0; i < 2; i++) begin
            start = access_total;
            sb_q.push_back({2'd3, 32'h0});
            issue(bad[i], 1'b0, 32'h0, 4'h0, acc);
            checks++;
            if ({rsp_valid, access_valid} !== 2'b10) begin
                errors++; $display("FAIL decode_latency addr=%h got=%b exp=10", bad[i], {rsp_valid, access_valid});
            end
            collect(10, ok, st, rd);
            e = sb_q.pop_front();
            checks++;
            if (!ok) begin errors++; $display("FAIL decode_rsp got=timeout exp=response"); end
            else if ({st, rd} !== e) begin errors++; $display("FAIL decode_rsp got=%h exp=%h", {st, rd}, e); end
            checks++;
            if (access_total - start !== 0) begin
                errors++; $display("FAIL decode_no_access got=%0d exp=0", access_total - start);
            end
        end
        sb_q.push_back({2'd0, 32'hA5A5A5A5});
        issue(8'h5F, 1'b0, 32'h0, 4'h0, acc);
        checks++;
        if ({access_valid, access_address} !== {1'b1, 8'h1F}) begin
            errors++; $display("FAIL last_addr got=%b/%h exp=1/1f", access_valid, access_address);
        end
        collect(10, ok, st, rd);
        e = sb_q.pop_front();
        checks++;
        if (!ok) begin errors++; $display("FAIL last_rsp got=timeout exp=response"); end
        else if ({st, rd} !== e) begin errors++; $display("FAIL last_rsp got=%h exp=%h", {st, rd}, e); end
    endtask

    task automatic test_no_active_hold();
        logic acc, ok, held;
        logic [1:0] st;
        logic [31:0] rd;
        logic [33:0] e;
        int start;
        reg_active = 2'b00; reg_ready = 2'b11; reg_value = {32'h5555AAAA, 32'h12121212};
        start = access_total;
        sb_q.push_back({2'd3, 32'h0});
        issue(8'h50, 1'b0, 32'h0, 4'h0, acc);
        step();
        held = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if ({rsp_valid, access_valid, req_ready, rsp_status, rsp_rdata} !== {3'b100, 2'd3, 32'h0}) held = 1'b0;
            step();
        end
        checks++;
        if (!held) begin errors++; $display("FAIL hold_stable got=unstable exp=stable"); end
        collect(10, ok, st, rd);
        e = sb_q.pop_front();
        checks++;
        if (!ok) begin errors++; $display("FAIL noactive_rsp got=timeout exp=response"); end
        else if ({st, rd} !== e) begin errors++; $display("FAIL noactive_rsp got=%h exp=%h", {st, rd}, e); end
        checks++;
        if (access_total - start !== 1) begin
            errors++; $display("FAIL noactive_cycles got=%0d exp=1", access_total - start);
        end
    endtask

    task automatic test_multi_active();
        logic acc, ok;
        logic [1:0] st;
        logic [31:0] rd;
        logic [33:0] e;
        reg_active = 2'b11; reg_status = {2'd2, 2'd1}; reg_value = {32'hF0F00000, 32'h0000000F};
        for (int i = 0; i < 2; i++) begin
            reg_ready = (i == 0) ? 2'b11 : 2'b01;
            sb_q.push_back((i == 0) ? {2'd3, 32'hF0F0000F} : {2'd1, 32'h0000000F});
            issue(8'h40, 1'b0, 32'h0, 4'h0, acc);
            collect(10, ok, st, rd);
            e = sb_q.pop_front();
            checks++;
            if (!ok) begin errors++; $display("FAIL multi_rsp got=timeout exp=response"); end
            else if ({st, rd} !== e) begin errors++; $display("FAIL multi_rsp%0d got=%h exp=%h", i, {st, rd}, e); end
        end
    endtask

    task automatic test_wait();
        logic acc, ok;
        logic [1:0] st;
        logic [31:0] rd;
        logic [33:0] e;
        int start;
        reg_active = 2'b01; reg_ready = 2'b00; reg_status = '0; reg_value = {32'h0, 32'h00000077};
        start = access_total;
        issue(8'h4C, 1'b0, 32'h0, 4'h0, acc);
`ifdef RGGEN_ACCESS_TIMEOUT_EN
        sb_q.push_back({2'd2, 32'h0});
        collect(20, ok, st, rd);
        checks++;
        if (access_total - start !== TO + 0) begin
            errors++; $display("FAIL timeout_cycles got=%0d exp=%0d", access_total - start, TO);
        end
`else
        repeat (20) step();
        checks++;
        if ({access_valid, rsp_valid} !== 2'b10) begin
            errors++; $display("FAIL wait_forever got=%b exp=10", {access_valid, rsp_valid});
        end
        reg_ready = 2'b01;
        sb_q.push_back({2'd0, 32'h00000077});
        collect(10, ok, st, rd);
`endif
        e = sb_q.pop_front();
        checks++;
        if (!ok) begin errors++; $display("FAIL wait_rsp got=timeout exp=response"); end
        else if ({st, rd} !== e) begin errors++; $display("FAIL wait_rsp got=%h exp=%h", {st, rd}, e); end
    endtask

    task automatic test_reset_mid_access();
        logic acc, quiet;
        reg_active = 2'b01; reg_ready = 2'b00;
        issue(8'h44, 1'b0, 32'h0, 4'h0, acc);
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if ({access_valid, rsp_valid, req_ready} !== 3'b001) begin
            errors++; $display("FAIL rst_mid got=%b exp=001", {access_valid, rsp_valid, req_ready});
        end
        quiet = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (rsp_valid !== 1'b0) quiet = 1'b0;
            step();
        end
        checks++;
        if (!quiet) begin errors++; $display("FAIL rst_mid_rsp got=rsp_valid exp=none"); end
        checks++;
        if (sb_q.size() != 0) begin errors++; $display("FAIL sb_empty got=%0d exp=0", sb_q.size()); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_read();
        test_write();
        test_decode_error();
        test_no_active_hold();
        test_multi_active();
        test_wait();
        test_reset_mid_access();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
